tx_path_top: RTL and testbench
==============================

# tx_path_top

Transmit-path front end: takes one QPSK symbol per handshake as two bits (I, Q) and emits a 24-bit AXI-Stream-style sample carrying two 12-bit signed constellation values. An optional zero-stuffing interpolator sits after the mapper. The output feeds the pulse-shaping FIR, which sees each 12-bit value zero-padded to 16 bits per lane. The block must sustain one symbol per clock under continuous ready and tolerate arbitrary backpressure.

## Interface
Parameters:
- DATA_W, 12, width of each output component.
- AMP, 12'h5A7, magnitude for a "+1.0" level (0.7071 in Q1.11); "-1.0" is its two's complement, 12'hA59.
- UPSAMPLE, 1, output beats per symbol (1..16); beats after the first carry zero.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on clk.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  block can accept a symbol.
- in_I  in  1  I bit of symbol.
- in_Q  in  1  Q bit of symbol.
- in_data  in  2  reserved {I,Q} stream port; ignored, leave unconnected.
- out_valid  out  1  output sample valid.
- out_data  out  2*DATA_W  {I[23:12], Q[11:0]}, signed two's complement.
- out_ready  in  1  downstream accepts sample.

## Operation
- Input transfer: a symbol is accepted on a rising edge when in_valid=1 and in_ready=1.
- Output transfer: a beat completes on a rising edge when out_valid=1 and out_ready=1.
- Mapping, applied to I and Q independently:
  - bit 0 -> +AMP (12'h5A7)
  - bit 1 -> -AMP (12'hA59)
  - No other nonzero value may ever appear on out_data.
- Buffering: two-entry symbol store (output register plus skid register).
  - in_ready = 1 when the skid entry is empty. in_ready is driven from a register, with no combinational path from out_ready.
  - A symbol accepted while the output register is empty, or is being drained this cycle, goes directly to the output register.
  - Otherwise the symbol goes to the skid entry, and in_ready drops on the next cycle.
- Interpolation:
  - A phase counter runs 0..UPSAMPLE-1 per symbol.
  - Phase 0 outputs the mapped symbol. Phases 1..UPSAMPLE-1 output 24'h000000 with out_valid=1.
  - The counter advances only on a completed output beat.
  - The symbol is released from the output register when the beat at phase UPSAMPLE-1 completes.
  - With UPSAMPLE=1 the counter is absent or constant 0.
- Stability: while out_valid=1 and out_ready=0, out_data and the phase must not change, and no symbol is lost or duplicated.
- Simultaneous accept and drain with a full skid: the skid moves to the output register and the new symbol is accepted into the skid. This is legal only because in_ready was 1.
- Reset (rst=0 at an edge) has priority over all other activity:
  - clears both entries and the phase counter;
  - sets out_valid=0, out_data=0, in_ready=0.
  - In-flight symbols are discarded.

## Timing
- Reset values: out_valid=0, out_data=24'h0, in_ready=0.
- in_ready rises on the first edge at which rst is sampled 1, so it is seen high in the cycle after reset release.
- Latency: a symbol accepted at edge N appears on out_data with out_valid=1 after edge N, i.e. one cycle, when the output register is free.
- Throughput: with out_ready held at 1 and UPSAMPLE=1, one symbol per clock and in_ready stays 1. With UPSAMPLE=U, one symbol per U clocks.
- Backpressure:
  - in_ready falls no later than one cycle after out_ready falls while a symbol is held.
  - At most 2 symbols are buffered.
  - in_ready rises one cycle after the skid entry drains.
- Outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset: hold rst=0 for 4 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout. One cycle after release, in_ready=1.
- Mapping: send (I,Q) = (0,0), (0,1), (1,0), (1,1) with out_ready=1 -> out_data = 5A7_5A7, 5A7_A59, A59_5A7, A59_A59, each one cycle after acceptance, in order.
- Streaming: 800 random symbols, in_valid=1, out_ready=1 -> 800 beats, order preserved, in_ready never drops, no value other than 5A7/A59.
- Backpressure: out_ready=0 for 5 cycles mid-stream -> out_data held stable, in_ready=0 after 2 symbols buffered. On release, buffered symbols emerge in order with none lost or duplicated.
- UPSAMPLE=4: send symbol (1,0) -> beats A59_5A7, 000000, 000000, 000000. in_ready throttles input to 1 symbol per 4 beats.
- Mid-stream reset: assert rst=0 with both entries full -> next cycle out_valid=0, out_data=0. After release, the first output is the first symbol sent after reset.

Source files
------------

// File: rtl/tx_path_top.sv
// QPSK transmit-path front end: maps one (I,Q) symbol per input handshake to
// a pair of signed DATA_W-bit constellation values, optionally zero-stuffs
// UPSAMPLE-1 extra beats per symbol, and buffers up to two symbols so that
// in_ready comes from a register and is never combinationally tied to
// out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   input symbol valid
//   in_ready   block can accept a symbol (registered)
//   in_I/in_Q  symbol bits; 0 -> +AMP, 1 -> -AMP
//   in_data    reserved {I,Q} port, ignored
//   out_valid  output beat valid (registered)
//   out_data   {I, Q} signed samples (registered)
//   out_ready  downstream accepts beat
module tx_path_top #(
  parameter int unsigned        DATA_W   = 12,
  parameter logic [DATA_W-1:0]  AMP      = 12'h5A7,
  parameter int unsigned        UPSAMPLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_I,
  input  logic                  in_Q,
  input  logic [1:0]            in_data,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_data,
  input  logic                  out_ready
);

  localparam int unsigned PH_W  = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam int unsigned OUT_W = 2 * DATA_W;

  // Reserved input port; kept only so it is not reported as dangling.
  logic w_unused_in_data;
  assign w_unused_in_data = ^in_data;

  // Symbol storage: output register plus skid entry, each holding {I,Q}.
  logic            r_out_vld;
  logic [1:0]      r_out_sym;
  logic            r_skid_vld;
  logic [1:0]      r_skid_sym;
  logic [PH_W-1:0] r_phase;
  logic            r_in_ready;
  logic [OUT_W-1:0] r_out_data;

  logic            w_out_vld_n;
  logic [1:0]      w_out_sym_n;
  logic            w_skid_vld_n;
  logic [1:0]      w_skid_sym_n;
  logic [PH_W-1:0] w_phase_n;
  logic [OUT_W-1:0] w_out_data_n;

  logic            w_beat;
  logic            w_last;
  logic            w_release;
  logic            w_accept;
  logic            w_out_free;
  logic [1:0]      w_in_sym;

  // One lane of the constellation: bit 0 -> +AMP, bit 1 -> -AMP.
  function automatic logic [DATA_W-1:0] map_lane(input logic b);
    return b ? DATA_W'(DATA_W'(0) - AMP) : AMP;
  endfunction

  assign w_in_sym   = {in_I, in_Q};
  assign w_beat     = r_out_vld && out_ready;
  assign w_last     = (r_phase == PH_W'(UPSAMPLE - 1));
  assign w_release  = w_beat && w_last;
  assign w_accept   = in_valid && r_in_ready;
  // Output register can take a new symbol this edge.
  assign w_out_free = !r_out_vld || w_release;

  // Next-state for phase, entries and the registered output word.
  always_comb begin
    w_phase_n    = r_phase;
    w_out_vld_n  = r_out_vld;
    w_out_sym_n  = r_out_sym;
    w_skid_vld_n = r_skid_vld;
    w_skid_sym_n = r_skid_sym;
    w_out_data_n = '0;

    if (w_release) begin
      w_phase_n = '0;
    end else if (w_beat) begin
      w_phase_n = PH_W'(r_phase + 1'b1);
    end

    if (w_out_free) begin
      if (r_skid_vld) begin
        // Skid refills the output; a concurrent accept takes the freed skid.
        w_out_vld_n  = 1'b1;
        w_out_sym_n  = r_skid_sym;
        w_skid_vld_n = w_accept;
        if (w_accept) begin
          w_skid_sym_n = w_in_sym;
        end
      end else begin
        w_out_vld_n = w_accept;
        if (w_accept) begin
          w_out_sym_n = w_in_sym;
        end
      end
    end else if (w_accept) begin
      w_skid_vld_n = 1'b1;
      w_skid_sym_n = w_in_sym;
    end

    // Phase 0 carries the mapped symbol; stuffed phases carry zero.
    if (w_out_vld_n && (w_phase_n == '0)) begin
      w_out_data_n = {map_lane(w_out_sym_n[1]), map_lane(w_out_sym_n[0])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_vld  <= 1'b0;
      r_out_sym  <= 2'b00;
      r_skid_vld <= 1'b0;
      r_skid_sym <= 2'b00;
      r_phase    <= '0;
      r_in_ready <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_vld  <= w_out_vld_n;
      r_out_sym  <= w_out_sym_n;
      r_skid_vld <= w_skid_vld_n;
      r_skid_sym <= w_skid_sym_n;
      r_phase    <= w_phase_n;
      r_in_ready <= !w_skid_vld_n;
      r_out_data <= w_out_data_n;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_tx_path_top.sv
module tb_tx_path_top;

  localparam logic [11:0] P = 12'h5A7;
  localparam logic [11:0] N = 12'hA59;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_I, in_Q, out_ready;
  logic [1:0] in_data;

  logic        rdy1, ov1, rdy4, ov4;
  logic [23:0] od1, od4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_path_top #(.DATA_W(12), .AMP(12'h5A7), .UPSAMPLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_I(in_I), .in_Q(in_Q), .in_data(in_data),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready));

  tx_path_top #(.DATA_W(12), .AMP(12'h5A7), .UPSAMPLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_I(in_I), .in_Q(in_Q), .in_data(in_data),
    .out_valid(ov4), .out_data(od4), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] sym_word(input logic [1:0] s);
    return {s[1] ? N : P, s[0] ? N : P};
  endfunction

  // Behavioural model: a FIFO of accepted symbols (depth 2), a beat index
  // within the current symbol, and the registered ready flag.
  logic [1:0] q1[$];
  logic [1:0] q4[$];
  int  ph1 = 0, ph4 = 0;
  bit  mr1 = 0, mr4 = 0;
  bit  started = 0;
  int  acc4 = 0;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      q1.delete(); q4.delete();
      ph1 = 0; ph4 = 0; mr1 = 0; mr4 = 0;
      started = 1;
    end else if (started) begin
      bit a1, a4;
      a1 = in_valid && mr1;
      a4 = in_valid && mr4;
      if (a4) acc4++;
      if (q1.size() > 0 && out_ready) begin
        void'(q1.pop_front());
        ph1 = 0;
      end
      if (q4.size() > 0 && out_ready) begin
        if (ph4 == 3) begin
          void'(q4.pop_front());
          ph4 = 0;
        end else ph4++;
      end
      if (a1) q1.push_back({in_I, in_Q});
      if (a4) q4.push_back({in_I, in_Q});
      mr1 = (q1.size() <= 1);
      mr4 = (q4.size() <= 1);
    end
  end

  // Compare both DUTs against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("u1_in_ready", 32'(rdy1), 32'(mr1));
      check("u1_out_valid", 32'(ov1), 32'(q1.size() > 0));
      if (q1.size() > 0) check("u1_out_data", 32'(od1), 32'(sym_word(q1[0])));
      check("u4_in_ready", 32'(rdy4), 32'(mr4));
      check("u4_out_valid", 32'(ov4), 32'(q4.size() > 0));
      if (q4.size() > 0)
        check("u4_out_data", 32'(od4), (ph4 == 0) ? 32'(sym_word(q4[0])) : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] map_exp [4];
  logic [23:0] up_exp [4];
  int ok_rdy;
  int acc_start;

  initial begin
    map_exp[0] = 24'h5A75A7; map_exp[1] = 24'h5A7A59;
    map_exp[2] = 24'hA595A7; map_exp[3] = 24'hA59A59;
    up_exp[0] = 24'hA595A7; up_exp[1] = 24'h0; up_exp[2] = 24'h0; up_exp[3] = 24'h0;
    in_data = 2'b00;
    rst = 1'b0; in_valid = 1'b1; in_I = 1'b0; in_Q = 1'b0; out_ready = 1'b1;

    // Reset held 4 cycles with valid input.
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_out_valid", 32'(ov1), 32'h0);
      check("rst_out_data", 32'(od1), 32'h0);
      check("rst_in_ready", 32'(rdy1), 32'h0);
    end
    rst = 1'b1; in_valid = 1'b0;
    step();
    check("rel_in_ready", 32'(rdy1), 32'h1);

    // Mapping of all four symbols, one cycle latency each.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_I = k[1]; in_Q = k[0];
      step();
      check("map_valid", 32'(ov1), 32'h1);
      check("map_data", 32'(od1), 32'(map_exp[k]));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();

    // UPSAMPLE=4: one symbol (1,0) gives one mapped beat and three zeros.
    in_valid = 1'b1; in_I = 1'b1; in_Q = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("up4_valid", 32'(ov4), 32'h1);
      check("up4_data", 32'(od4), 32'(up_exp[k]));
      step();
    end
    check("up4_idle", 32'(ov4), 32'h0);

    // Throttle: 40 cycles of continuous input into the x4 instance.
    acc_start = acc4;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_I = 1'($urandom); in_Q = 1'($urandom);
      step();
    end
    check("up4_rate", 32'((acc4 - acc_start) >= 10 && (acc4 - acc_start) <= 12), 32'h1);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();

    // Streaming 800 symbols at full rate; ready must never drop.
    ok_rdy = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 800; i++) begin
      in_I = 1'($urandom); in_Q = 1'($urandom);
      if (rdy1) ok_rdy++;
      step();
    end
    check("stream_ready_cnt", 32'(ok_rdy), 32'd800);

    // Backpressure mid-stream for 5 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_I = 1'($urandom); in_Q = 1'($urandom);
      step();
    end
    check("bp_in_ready", 32'(rdy1), 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_I = 1'($urandom); in_Q = 1'($urandom);
      step();
    end

    // Mid-stream reset with both entries full.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("full_in_ready", 32'(rdy1), 32'h0);
    rst = 1'b0;
    step();
    check("mrst_valid", 32'(ov1), 32'h0);
    check("mrst_data", 32'(od1), 32'h0);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_I = 1'b0; in_Q = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(ov1), 32'h1);
    check("post_rst_data", 32'(od1), 32'h5A7A59);
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
